// File: rtl/ldpc_cn_pkg.sv
// Shared definitions for the LDPC check-node processors: FSM encoding,
// sign-magnitude field helpers and the all-ones magnitude constant.
package ldpc_cn_pkg;

   // Check-node FSM encoding
   localparam logic [0:0] ST_COLLECT = 1'b0;
   localparam logic [0:0] ST_EMIT    = 1'b1;

   // All-ones magnitude; truncate to the magnitude width at the use site
   localparam logic [31:0] MAX_MAG = 32'hFFFF_FFFF;

   // Sign bit of a sign-magnitude message of width w (message zero-extended to 32 bits)
   function automatic logic sgn_of(input logic [31:0] msg, input int w);
      logic [31:0] sh;
      sh = msg >> (w - 1);
      return sh[0];
   endfunction

   // Magnitude field of a sign-magnitude message of width w
   function automatic logic [31:0] mag_of(input logic [31:0] msg, input int w);
      return msg & ((32'd1 << (w - 1)) - 32'd1);
   endfunction

endpackage

// File: rtl/cn_min_tracker.sv
// Combinational two-minimum tracker: folds one new magnitude into the
// running (min1, min2, idx1) triple. A tie with min1 lands in min2 so that
// idx1 always names the first edge that reached the minimum.
module cn_min_tracker
   import ldpc_cn_pkg::*;
#(
   parameter int MAG_W = 10,
   parameter int IDX_W = 3
) (
   input  logic [MAG_W-1:0] m_i,
   input  logic [IDX_W-1:0] k_i,
   input  logic [MAG_W-1:0] min1_i,
   input  logic [MAG_W-1:0] min2_i,
   input  logic [IDX_W-1:0] idx1_i,
   output logic [MAG_W-1:0] min1_o,
   output logic [MAG_W-1:0] min2_o,
   output logic [IDX_W-1:0] idx1_o
);

   // Insert m into the sorted pair of smallest magnitudes
   always_comb begin
      min1_o = min1_i;
      min2_o = min2_i;
      idx1_o = idx1_i;
      if (m_i < min1_i) begin
         min2_o = min1_i;
         min1_o = m_i;
         idx1_o = k_i;
      end else if (m_i < min2_i) begin
         min2_o = m_i;
      end else begin
         min2_o = min2_i;
      end
   end

endmodule

// File: rtl/cn_serial_minsum.sv
// Serial offset-min-sum check-node processor. Collects DEGREE
// variable-to-check messages, then emits DEGREE extrinsic check-to-variable
// messages in edge order. One node at a time; no overlap.
module cn_serial_minsum
   import ldpc_cn_pkg::*;
#(
   parameter int MSG_W  = 11,
   parameter int DEGREE = 6,
   parameter int OFFSET = 0,
   parameter int IDX_W  = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [MSG_W-1:0] in_msg,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [MSG_W-1:0] out_msg,
   output logic [IDX_W-1:0] out_idx,
   output logic             cn_done
);

   localparam int               MAG_W    = MSG_W - 1;
   localparam logic [MAG_W-1:0] MAG_ONES = MAG_W'(MAX_MAG);
   localparam logic [MAG_W-1:0] OFF_C    = MAG_W'(OFFSET);
   localparam logic [IDX_W-1:0] LAST_C   = IDX_W'(DEGREE - 1);

   logic [0:0]        state_q;
   logic [IDX_W-1:0]  cnt_q;
   logic [MAG_W-1:0]  min1_q, min2_q;
   logic [IDX_W-1:0]  idx1_q;
   logic              prod_q;
   logic [DEGREE-1:0] sign_q;
   logic [MSG_W-1:0]  out_msg_q;
   logic [IDX_W-1:0]  out_idx_q;

   logic              in_fire_s, out_fire_s, last_s, in_sgn_s;
   logic [MAG_W-1:0]  in_mag_s;
   logic [MAG_W-1:0]  trk_min1_s, trk_min2_s;
   logic [IDX_W-1:0]  trk_idx1_s;
   logic [DEGREE-1:0] sign_nxt_s;

   logic [MAG_W-1:0]  src_min1_s, src_min2_s, sel_mag_s, mag_o_s;
   logic [IDX_W-1:0]  src_idx1_s, tgt_idx_s;
   logic [DEGREE-1:0] src_sign_s;
   logic              src_prod_s, sgn_o_s;

   assign in_ready   = (state_q == ST_COLLECT);
   assign out_valid  = (state_q == ST_EMIT);
   assign out_msg    = out_msg_q;
   assign out_idx    = out_idx_q;
   assign in_fire_s  = in_valid && in_ready;
   assign out_fire_s = out_valid && out_ready;
   assign last_s     = (cnt_q == LAST_C);
   assign cn_done    = out_fire_s && last_s;

   assign in_sgn_s = sgn_of(32'(in_msg), MSG_W);
   assign in_mag_s = MAG_W'(mag_of(32'(in_msg), MSG_W));

   cn_min_tracker #(
      .MAG_W (MAG_W),
      .IDX_W (IDX_W)
   ) u_trk (
      .m_i    (in_mag_s),
      .k_i    (cnt_q),
      .min1_i (min1_q),
      .min2_i (min2_q),
      .idx1_i (idx1_q),
      .min1_o (trk_min1_s),
      .min2_o (trk_min2_s),
      .idx1_o (trk_idx1_s)
   );

   // Sign vector with the incoming sign written at the current edge
   always_comb begin
      sign_nxt_s        = sign_q;
      sign_nxt_s[cnt_q] = in_sgn_s;
   end

   // Next output message: edge 0 from the just-completed min state when the
   // last input lands, otherwise the following edge from the stored state
   always_comb begin
      if (state_q == ST_COLLECT) begin
         src_min1_s = trk_min1_s;
         src_min2_s = trk_min2_s;
         src_idx1_s = trk_idx1_s;
         src_sign_s = sign_nxt_s;
         src_prod_s = prod_q ^ in_sgn_s;
         tgt_idx_s  = '0;
      end else begin
         src_min1_s = min1_q;
         src_min2_s = min2_q;
         src_idx1_s = idx1_q;
         src_sign_s = sign_q;
         src_prod_s = prod_q;
         tgt_idx_s  = last_s ? '0 : cnt_q + IDX_W'(1);
      end
      if (tgt_idx_s == src_idx1_s) begin
         sel_mag_s = src_min2_s;
      end else begin
         sel_mag_s = src_min1_s;
      end
      if (sel_mag_s > OFF_C) begin
         mag_o_s = sel_mag_s - OFF_C;
      end else begin
         mag_o_s = '0;
      end
      if (mag_o_s == '0) begin
         sgn_o_s = 1'b0;
      end else begin
         sgn_o_s = src_prod_s ^ src_sign_s[tgt_idx_s];
      end
   end

   // FSM, edge counter, min/sign state and registered output message
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_COLLECT;
         cnt_q     <= '0;
         min1_q    <= MAG_ONES;
         min2_q    <= MAG_ONES;
         idx1_q    <= '0;
         prod_q    <= 1'b0;
         sign_q    <= '0;
         out_msg_q <= '0;
         out_idx_q <= '0;
      end else begin
         case (state_q)
            ST_COLLECT: begin
               if (in_fire_s) begin
                  min1_q <= trk_min1_s;
                  min2_q <= trk_min2_s;
                  idx1_q <= trk_idx1_s;
                  sign_q <= sign_nxt_s;
                  prod_q <= prod_q ^ in_sgn_s;
                  if (last_s) begin
                     cnt_q     <= '0;
                     state_q   <= ST_EMIT;
                     out_msg_q <= {sgn_o_s, mag_o_s};
                     out_idx_q <= tgt_idx_s;
                  end else begin
                     cnt_q <= cnt_q + IDX_W'(1);
                  end
               end
            end
            ST_EMIT: begin
               if (out_fire_s) begin
                  if (last_s) begin
                     state_q   <= ST_COLLECT;
                     cnt_q     <= '0;
                     min1_q    <= MAG_ONES;
                     min2_q    <= MAG_ONES;
                     idx1_q    <= '0;
                     prod_q    <= 1'b0;
                     sign_q    <= '0;
                     out_msg_q <= '0;
                     out_idx_q <= '0;
                  end else begin
                     cnt_q     <= cnt_q + IDX_W'(1);
                     out_msg_q <= {sgn_o_s, mag_o_s};
                     out_idx_q <= tgt_idx_s;
                  end
               end
            end
            default: begin
               state_q <= ST_COLLECT;
               cnt_q   <= '0;
            end
         endcase
      end
   end

endmodule
